seq_multiplier: RTL and testbench

- Sequential unsigned shift-add multiplier. It is the inverse-operation companion to the team's sequential divider.
- It uses the same start/busy/valid handshake and result/flag style, so the top level can host both behind one operand bus.
- Computes P = A × B over WIDTH iterations. Outputs the low WIDTH bits as the answer, the full 2×WIDTH product, and an overflow flag.

---
 rtl/seq_multiplier.sv | 156 +++++++++++++++
 tb/tb_seq_multiplier.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_multiplier.sv
// seq_multiplier: sequential unsigned shift-add multiplier.
//
// Computes P = data_A * data_B over WIDTH iterations using a start/busy/valid
// handshake that matches the team's sequential divider. When either operand
// is zero the operation finishes immediately through a short-cut.
//
// Ports:
//   clk          in   system clock, rising-edge active
//   rst_n        in   asynchronous active-low reset
//   start        in   operation request, accepted in IDLE or DONE
//   data_A       in   multiplicand (WIDTH bits), captured on the accepting edge
//   data_B       in   multiplier (WIDTH bits), captured on the accepting edge
//   busy         out  high while iterating (state CALC)
//   valid        out  one-cycle pulse when a new result is presented (state DONE)
//   answer       out  low WIDTH bits of the product, held until the next result
//   product_full out  full 2*WIDTH-bit product, held until the next result
//   ovf_flag     out  upper WIDTH bits of the product are nonzero
//   zero_flag    out  result came from the zero-operand short-cut
module seq_multiplier #(
  parameter int WIDTH = 10,
  parameter int CNT_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   data_A,
  input  logic [WIDTH-1:0]   data_B,
  output logic               busy,
  output logic               valid,
  output logic [WIDTH-1:0]   answer,
  output logic [2*WIDTH-1:0] product_full,
  output logic               ovf_flag,
  output logic               zero_flag
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   answer_q, answer_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic               ovf_q, ovf_d;
  logic               zero_q, zero_d;

  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   acc_shift;
  logic [WIDTH-1:0]   q_shift;

  // One shift-add step: add the multiplicand when the current multiplier bit
  // is set, then shift the {carry, ACC, Q} chain right by one. The carry out
  // of the add lands in the top of ACC and the low ACC bit moves into Q.
  always_comb begin
    sum       = {1'b0, acc_q} + (q_q[0] ? {1'b0, m_q} : '0);
    acc_shift = sum[WIDTH:1];
    q_shift   = {sum[0], q_q[WIDTH-1:1]};
  end

  // Next-state and datapath control. Start is honoured in IDLE and DONE so
  // that a held start chains operations with only the DONE cycle between
  // them. Result registers are written only on the edge entering DONE.
  always_comb begin
    state_d  = state_q;
    m_d      = m_q;
    acc_d    = acc_q;
    q_d      = q_q;
    cnt_d    = cnt_q;
    answer_d = answer_q;
    prod_d   = prod_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          m_d   = data_A;
          q_d   = data_B;
          acc_d = '0;
          cnt_d = '0;
          if ((data_A == '0) || (data_B == '0)) begin
            state_d  = DONE;
            prod_d   = '0;
            answer_d = '0;
            ovf_d    = 1'b0;
            zero_d   = 1'b1;
          end else begin
            state_d = CALC;
          end
        end else begin
          state_d = IDLE;
        end
      end

      CALC: begin
        acc_d = acc_shift;
        q_d   = q_shift;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          // The final shift completes the product; latch it straight from
          // the shifter so it is visible in the DONE cycle.
          state_d  = DONE;
          prod_d   = {acc_shift, q_shift};
          answer_d = q_shift;
          ovf_d    = |acc_shift;
          zero_d   = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset clears everything immediately so an
  // aborted operation leaves no stale result behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      m_q      <= '0;
      acc_q    <= '0;
      q_q      <= '0;
      cnt_q    <= '0;
      answer_q <= '0;
      prod_q   <= '0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      m_q      <= m_d;
      acc_q    <= acc_d;
      q_q      <= q_d;
      cnt_q    <= cnt_d;
      answer_q <= answer_d;
      prod_q   <= prod_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  assign busy         = (state_q == CALC);
  assign valid        = (state_q == DONE);
  assign answer       = answer_q;
  assign product_full = prod_q;
  assign ovf_flag     = ovf_q;
  assign zero_flag    = zero_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier: self-checking bench for seq_multiplier.
//
// Expected results come from a behavioural multiply pushed onto a scoreboard
// queue when an operation is accepted, and popped when valid is observed.
module tb_seq_multiplier;

  localparam int WIDTH = 10;
  localparam int CNT_W = 4;

  typedef struct packed {
    logic [WIDTH-1:0]   ans;
    logic [2*WIDTH-1:0] prod;
    logic               ovf;
    logic               zero;
  } res_t;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic [WIDTH-1:0]   dataA;
  logic [WIDTH-1:0]   dataB;
  logic               busy;
  logic               valid;
  logic [WIDTH-1:0]   answer;
  logic [2*WIDTH-1:0] productFull;
  logic               ovfFlag;
  logic               zeroFlag;

  int   checks   = 0;
  int   failures = 0;
  res_t sb[$];
  res_t prevRes;

  seq_multiplier #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .data_A      (dataA),
    .data_B      (dataB),
    .busy        (busy),
    .valid       (valid),
    .answer      (answer),
    .product_full(productFull),
    .ovf_flag    (ovfFlag),
    .zero_flag   (zeroFlag)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something outside the bounded waits stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Reference result from a plain full-width multiply.
  function automatic res_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    res_t r;
    logic [2*WIDTH-1:0] p;
    p      = (2*WIDTH)'(a) * (2*WIDTH)'(b);
    r.prod = p;
    r.ans  = p[WIDTH-1:0];
    r.ovf  = |p[2*WIDTH-1:WIDTH];
    r.zero = (a == '0) || (b == '0);
    return r;
  endfunction

  function automatic res_t outputsNow();
    res_t r;
    r.ans  = answer;
    r.prod = productFull;
    r.ovf  = ovfFlag;
    r.zero = zeroFlag;
    return r;
  endfunction

  // Pulse start for one accepting edge and record the expected result.
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    @(negedge clk);
    dataA = a;
    dataB = b;
    start = 1'b1;
    @(posedge clk);
    sb.push_back(model(a, b));
    #1;
    start = 1'b0;
  endtask

  // Observe until valid (bounded). latency counts edges from the accepting
  // edge inclusive; 0 means no valid was seen. Also records busy cycles and
  // whether the held results stayed put while waiting.
  task automatic collectResult(input int maxCycles, output int latency,
                               output int busyCycles, output bit heldOk,
                               output res_t got);
    latency    = 0;
    busyCycles = 0;
    heldOk     = 1'b1;
    got        = '0;
    for (int n = 1; n <= maxCycles; n++) begin
      @(negedge clk);
      if (valid === 1'b1) begin
        latency = n;
        got     = outputsNow();
        break;
      end
      if (busy === 1'b1) busyCycles++;
      if (outputsNow() !== prevRes) heldOk = 1'b0;
      @(posedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    dataA = '0;
    dataB = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_busy: got %b want 0", busy);
    end
    checks++;
    if (valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_valid: got %b want 0", valid);
    end
    checks++;
    if (outputsNow() !== res_t'(0)) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got %h want 0", outputsNow());
    end
    prevRes = '0;
  endtask

  task automatic test_basic();
    int lat, bcy;
    bit held;
    res_t got, exp;
    applyStimulus(10'd25, 10'd17);
    collectResult(40, lat, bcy, held, got);
    exp = sb.pop_front();
    checks++;
    if (lat != WIDTH + 1) begin
      failures++;
      $display("[TB] FAIL basic_latency: got %0d want %0d", lat, WIDTH + 1);
    end
    checks++;
    if (bcy != WIDTH) begin
      failures++;
      $display("[TB] FAIL basic_busy_cycles: got %0d want %0d", bcy, WIDTH);
    end
    checks++;
    if (!held) begin
      failures++;
      $display("[TB] FAIL basic_held: results changed before valid, got %b want 1", held);
    end
    checks++;
    if (got !== exp || got.ans !== 10'd425) begin
      failures++;
      $display("[TB] FAIL basic_result: got %h want %h", got, exp);
    end
    prevRes = got;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL basic_pulse: got valid=%b busy=%b want 0/0", valid, busy);
    end
  endtask

  task automatic test_overflow();
    logic [WIDTH-1:0] as[2] = '{10'd40, 10'd1023};
    logic [WIDTH-1:0] bs[2] = '{10'd30, 10'd1023};
    int lat, bcy;
    bit held;
    res_t got, exp;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(as[i], bs[i]);
      collectResult(40, lat, bcy, held, got);
      exp = sb.pop_front();
      checks++;
      if (lat != WIDTH + 1) begin
        failures++;
        $display("[TB] FAIL ovf_latency[%0d]: got %0d want %0d", i, lat, WIDTH + 1);
      end
      checks++;
      if (got !== exp || got.ovf !== 1'b1) begin
        failures++;
        $display("[TB] FAIL ovf_result[%0d]: got %h want %h", i, got, exp);
      end
      checks++;
      if (!held) begin
        failures++;
        $display("[TB] FAIL ovf_held[%0d]: got %b want 1", i, held);
      end
      prevRes = got;
    end
  endtask

  task automatic test_zero();
    logic [WIDTH-1:0] as[2] = '{10'd0, 10'd5};
    logic [WIDTH-1:0] bs[2] = '{10'd999, 10'd0};
    int lat, bcy;
    bit held;
    res_t got, exp;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(as[i], bs[i]);
      collectResult(40, lat, bcy, held, got);
      exp = sb.pop_front();
      checks++;
      if (lat != 1) begin
        failures++;
        $display("[TB] FAIL zero_latency[%0d]: got %0d want 1", i, lat);
      end
      checks++;
      if (got !== exp || got.zero !== 1'b1) begin
        failures++;
        $display("[TB] FAIL zero_result[%0d]: got %h want %h", i, got, exp);
      end
      prevRes = got;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || valid !== 1'b0) begin
        failures++;
        $display("[TB] FAIL zero_after[%0d]: got busy=%b valid=%b want 0/0", i, busy, valid);
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat, bcy;
    bit held;
    res_t got, exp;
    applyStimulus(10'd3, 10'd7);
    repeat (3) @(posedge clk);
    // Start pulse mid-calculation with different operands must be ignored.
    @(negedge clk);
    dataA = 10'd9;
    dataB = 10'd9;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    // Hold start for the chained operation.
    @(negedge clk);
    dataA = 10'd2;
    dataB = 10'd2;
    start = 1'b1;
    collectResult(40, lat, bcy, held, got);
    exp = sb.pop_front();
    checks++;
    if (lat == 0) begin
      failures++;
      $display("[TB] FAIL b2b_first_timeout: got latency 0 want valid");
    end
    checks++;
    if (got !== exp || got.ans !== 10'd21) begin
      failures++;
      $display("[TB] FAIL b2b_first_result: got %h want %h", got, exp);
    end
    prevRes = got;
    // The DONE cycle with start high is itself an accepting edge.
    @(posedge clk);
    sb.push_back(model(10'd2, 10'd2));
    #1;
    start = 1'b0;
    collectResult(40, lat, bcy, held, got);
    exp = sb.pop_front();
    checks++;
    if (lat != WIDTH + 1 || bcy != WIDTH) begin
      failures++;
      $display("[TB] FAIL b2b_second_timing: got latency=%0d busy=%0d want %0d/%0d",
               lat, bcy, WIDTH + 1, WIDTH);
    end
    checks++;
    if (got !== exp || got.ans !== 10'd4) begin
      failures++;
      $display("[TB] FAIL b2b_second_result: got %h want %h", got, exp);
    end
    checks++;
    if (!held) begin
      failures++;
      $display("[TB] FAIL b2b_held: got %b want 1", held);
    end
    prevRes = got;
  endtask

  task automatic test_reset_mid();
    int lat, bcy, sawValid, sawBusy;
    bit held;
    res_t got, exp;
    applyStimulus(10'd100, 10'd10);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midreset_ctrl: got busy=%b valid=%b want 0/0", busy, valid);
    end
    checks++;
    if (outputsNow() !== res_t'(0)) begin
      failures++;
      $display("[TB] FAIL midreset_outputs: got %h want 0", outputsNow());
    end
    void'(sb.pop_back());
    prevRes = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sawValid = 0;
    sawBusy  = 0;
    repeat (WIDTH + 3) begin
      @(negedge clk);
      if (valid === 1'b1) sawValid++;
      if (busy === 1'b1) sawBusy++;
    end
    checks++;
    if (sawValid != 0 || sawBusy != 0) begin
      failures++;
      $display("[TB] FAIL midreset_idle: got valid=%0d busy=%0d cycles want 0/0", sawValid, sawBusy);
    end
    applyStimulus(10'd6, 10'd7);
    collectResult(40, lat, bcy, held, got);
    exp = sb.pop_front();
    checks++;
    if (lat != WIDTH + 1) begin
      failures++;
      $display("[TB] FAIL midreset_latency: got %0d want %0d", lat, WIDTH + 1);
    end
    checks++;
    if (got !== exp || got.ans !== 10'd42) begin
      failures++;
      $display("[TB] FAIL midreset_result: got %h want %h", got, exp);
    end
    prevRes = got;
  endtask

  // Scenario sequence and summary.
  initial begin
    prevRes = '0;
    test_reset();
    test_basic();
    test_overflow();
    test_zero();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_drain: got %0d entries want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
